// File: rtl/nrd_div_ctrl.sv
// nrd_div_ctrl -- sequencing controller for an unsigned non-restoring divider.
//
// Accepts a dividend/divisor pair on a start/done handshake, runs one
// non-restoring iteration per clock for WIDTH clocks, applies the final
// remainder correction, and holds quotient/remainder until the next done.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   start      request, sampled only while idle
//   dividend   unsigned dividend, captured on the accepting edge
//   divisor    unsigned divisor, captured on the accepting edge
//   busy       high while an operation is in flight (decoded from state)
//   done       one-cycle pulse when quotient/remainder become valid
//   quotient   registered quotient, held until the next done
//   remainder  registered remainder, held until the next done
//   div_zero   divisor-was-zero flag, updated with done
//
// Build option: DIV_BY_ZERO_DETECT_EN -- when defined, a zero divisor is
// answered on the accepting edge (quotient all ones, remainder = dividend,
// div_zero = 1) without running the iteration. When undefined, a zero divisor
// runs the normal sequence, which naturally yields the same quotient and
// remainder, and div_zero stays 0.

module nrd_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITER    = 2'd1,
    CORRECT = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_zero_r;

  logic [WIDTH:0]   m_ext_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   a_step_s;
  logic [WIDTH:0]   a_corr_s;
  logic             last_iter_s;
  logic             zero_div_s;

  assign m_ext_s     = {1'b0, m_r};
  // Partial remainder shifted left with the next dividend bit pulled in from Q.
  assign shift_s     = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign last_iter_s = (cnt_r == CW'(WIDTH - 1));

`ifdef DIV_BY_ZERO_DETECT_EN
  assign zero_div_s = (divisor == {WIDTH{1'b0}});
`else
  assign zero_div_s = 1'b0;
`endif

  // Non-restoring step and final correction arithmetic (modulo 2^(WIDTH+1)).
  always_comb begin
    a_step_s = shift_s - m_ext_s;
    a_corr_s = a_r;
    if (a_r[WIDTH]) begin
      a_step_s = shift_s + m_ext_s;
      a_corr_s = a_r + m_ext_s;
    end else begin
      a_step_s = shift_s - m_ext_s;
      a_corr_s = a_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        // A zero divisor under detection is answered without leaving IDLE.
        if (start && !zero_div_s) begin
          state_nxt_s = ITER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ITER: begin
        if (last_iter_s) begin
          state_nxt_s = CORRECT;
        end else begin
          state_nxt_s = ITER;
        end
      end
      CORRECT: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath registers and result/handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= {(WIDTH+1){1'b0}};
      q_r         <= {WIDTH{1'b0}};
      m_r         <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      div_zero_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r   <= {(WIDTH+1){1'b0}};
            q_r   <= dividend;
            m_r   <= divisor;
            cnt_r <= {CW{1'b0}};
            if (zero_div_s) begin
              done_r      <= 1'b1;
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= dividend;
              div_zero_r  <= 1'b1;
            end
          end
        end
        ITER: begin
          a_r   <= a_step_s;
          q_r   <= {q_r[WIDTH-2:0], ~a_step_s[WIDTH]};
          cnt_r <= cnt_r + CW'(1);
        end
        CORRECT: begin
          a_r         <= a_corr_s;
          quotient_r  <= q_r;
          remainder_r <= a_corr_s[WIDTH-1:0];
          done_r      <= 1'b1;
          div_zero_r  <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_nrd_div_ctrl.sv
// Self-checking bench for nrd_div_ctrl. Expected results come from plain
// integer division in the bench; latency and busy expectations come from the
// documented timing (33 edges per operation, or 0 for an early zero-divisor
// answer when DIV_BY_ZERO_DETECT_EN is defined).

module tb_nrd_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int n_assert;
  int n_fail;
  logic [31:0] prev_q;
  logic [31:0] prev_r;

`ifdef DIV_BY_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  nrd_div_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an operation and let one edge accept it; leaves time #1 past that edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Count edges from acceptance until done is seen (bounded).
  task automatic wait_done(input bit hold, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bcnt++;
      if (lat == 16) begin
        chk("held_quotient", quotient, prev_q);
        chk("held_remainder", remainder, prev_r);
      end
      if (hold) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Compare the just-completed operation against the arithmetic reference.
  task automatic check_res(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int bcnt);
    logic [31:0] eq, er;
    int          elat, ebusy;
    logic        edz;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    edz   = DZ_EN && (b == 32'd0);
    elat  = edz ? 0 : 33;
    ebusy = edz ? 0 : 33;
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(ebusy));
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic pulse_chk(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat, bcnt;
    issue(a, b);
    wait_done(1'b0, lat, bcnt);
    check_res(tag, a, b, lat, bcnt);
    pulse_chk(tag);
  endtask

  initial begin
    int          lat, bcnt;
    logic [31:0] ra, rb;
    n_assert = 0;
    n_fail   = 0;
    prev_q   = 32'd0;
    prev_r   = 32'd0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("d100_7", 32'd100, 32'd7);
    run_op("dmax_1", 32'hFFFF_FFFF, 32'd1);
    run_op("d5_10", 32'd5, 32'd10);
    run_op("dzero", 32'h1234_5678, 32'd0);
    run_op("d9_3", 32'd9, 32'd3);

    // Start held high with changing operands while busy, then a new start in the done cycle.
    issue(32'd50000, 32'd123);
    wait_done(1'b1, lat, bcnt);
    check_res("hold", 32'd50000, 32'd123, lat, bcnt);
    issue(32'd1000, 32'd3);
    wait_done(1'b0, lat, bcnt);
    check_res("b2b", 32'd1000, 32'd3, lat, bcnt);
    pulse_chk("b2b");

    // Reset in the middle of an operation.
    issue(32'h0BAD_F00D, 32'd77);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_div_zero", {31'd0, div_zero}, 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    prev_q = 32'd0;
    prev_r = 32'd0;
    @(posedge clk); #1;
    run_op("d81_9", 32'd81, 32'd9);

    // Randomised sweep with nonzero divisors of varied magnitude.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      issue(ra, rb);
      wait_done(1'b0, lat, bcnt);
      check_res("rand", ra, rb, lat, bcnt);
      chk("rand_identity",
          {31'd0, (64'(quotient) * 64'(rb) + 64'(remainder)) == 64'(ra)}, 32'd1);
      chk("rand_rem_lt_div", {31'd0, remainder < rb}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
